// File: rtl/lz_pkg.sv
// rtl/lz_pkg.sv - shared constants, token field widths and decoder state type
package lz_pkg;

    localparam int SEARCH_LEN = 9;
    localparam int MAX_MATCH  = 7;
    localparam int OFF_W      = 4;
    localparam int LEN_W      = 4;
    localparam int CHAR_W     = 8;

    localparam logic [CHAR_W-1:0] END_CHAR = 8'h24;

    typedef enum logic [1:0] {
        IDLE,
        COPY,
        LIT,
        DONE
    } state_t;

endpackage

// File: rtl/lz_token_decoder_if.sv
// rtl/lz_token_decoder_if.sv - token input and character output bundle for the decoder
// Ports (signals):
//   token_valid/token_offset/token_len/token_char : token from upstream encoder
//   busy     : decoder cannot accept a token this cycle
//   valid    : char_out holds a decoded character
//   char_out : decoded character
//   finish   : sticky, terminator has been emitted
// master = token source / character sink, slave = decoder.
interface lz_token_decoder_if;
    import lz_pkg::*;

    logic              token_valid;
    logic [OFF_W-1:0]  token_offset;
    logic [LEN_W-1:0]  token_len;
    logic [CHAR_W-1:0] token_char;
    logic              busy;
    logic              valid;
    logic [CHAR_W-1:0] char_out;
    logic              finish;

    modport master (
        output token_valid, token_offset, token_len, token_char,
        input  busy, valid, char_out, finish
    );

    modport slave (
        input  token_valid, token_offset, token_len, token_char,
        output busy, valid, char_out, finish
    );

endinterface

// File: rtl/lz_search_window.sv
// rtl/lz_search_window.sv - sliding window of recently emitted characters
// Ports:
//   clk, reset (async, active-high) : clock / clears every entry to 0
//   shift_en : push shift_in into entry 0, oldest entry drops out
//   shift_in : character to push
//   rd_idx   : read index, 0 = newest; indices >= DEPTH read 0
//   rd_data  : combinational read data
module lz_search_window
    import lz_pkg::*;
#(
    parameter int DEPTH = SEARCH_LEN
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              shift_en,
    input  logic [CHAR_W-1:0] shift_in,
    input  logic [OFF_W-1:0]  rd_idx,
    output logic [CHAR_W-1:0] rd_data
);

    logic [CHAR_W-1:0] win [DEPTH];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                win[i] <= '0;
            end
        end else if (shift_en) begin
            win[0] <= shift_in;
            for (int i = 1; i < DEPTH; i++) begin
                win[i] <= win[i-1];
            end
        end
    end

    always_comb begin
        rd_data = '0;
        if (int'(rd_idx) < DEPTH) begin
            rd_data = win[rd_idx];
        end
    end

endmodule

// File: rtl/lz_token_decoder.sv
// rtl/lz_token_decoder.sv - LZ77 token decoder, one output character per cycle
// Ports:
//   clk   : clock
//   reset : asynchronous, active-high; clears outputs, state and window
//   bus   : slave side of lz_token_decoder_if (token in, characters out)
// Parameters:
//   SEARCH_LEN : window depth in characters
//   END_CHAR   : terminator literal; emitting it parks the decoder in DONE
module lz_token_decoder #(
    parameter int          SEARCH_LEN = lz_pkg::SEARCH_LEN,
    parameter logic [7:0]  END_CHAR   = lz_pkg::END_CHAR
) (
    input  logic              clk,
    input  logic              reset,
    lz_token_decoder_if.slave bus
);
    import lz_pkg::*;

    state_t            state, state_nxt;
    logic [OFF_W-1:0]  off, off_nxt;
    logic [LEN_W-1:0]  cnt, cnt_nxt;
    logic [CHAR_W-1:0] lit, lit_nxt;

    logic              busy_r, busy_nxt;
    logic              valid_r, valid_nxt;
    logic [CHAR_W-1:0] char_r, char_nxt;
    logic              finish_r, finish_nxt;

    logic              shift_en;
    logic [CHAR_W-1:0] shift_in;
    logic [CHAR_W-1:0] win_rd;

    // The offset is held for the whole copy: the window shifts under it,
    // which is what makes overlapping copies replay correctly.
    lz_search_window #(
        .DEPTH (SEARCH_LEN)
    ) u_window (
        .clk      (clk),
        .reset    (reset),
        .shift_en (shift_en),
        .shift_in (shift_in),
        .rd_idx   (off),
        .rd_data  (win_rd)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            off      <= '0;
            cnt      <= '0;
            lit      <= '0;
            busy_r   <= 1'b0;
            valid_r  <= 1'b0;
            char_r   <= '0;
            finish_r <= 1'b0;
        end else begin
            state    <= state_nxt;
            off      <= off_nxt;
            cnt      <= cnt_nxt;
            lit      <= lit_nxt;
            busy_r   <= busy_nxt;
            valid_r  <= valid_nxt;
            char_r   <= char_nxt;
            finish_r <= finish_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        off_nxt    = off;
        cnt_nxt    = cnt;
        lit_nxt    = lit;
        valid_nxt  = 1'b0;
        char_nxt   = char_r;
        finish_nxt = finish_r;
        shift_en   = 1'b0;
        shift_in   = lit;

        case (state)
            IDLE: begin
                if (bus.token_valid) begin
                    off_nxt   = bus.token_offset;
                    cnt_nxt   = bus.token_len;
                    lit_nxt   = bus.token_char;
                    state_nxt = (bus.token_len != '0) ? COPY : LIT;
                end
            end
            COPY: begin
                shift_en  = 1'b1;
                shift_in  = win_rd;
                char_nxt  = win_rd;
                valid_nxt = 1'b1;
                cnt_nxt   = cnt - 1'b1;
                if (cnt == 4'd1) begin
                    state_nxt = LIT;
                end
            end
            LIT: begin
                shift_en  = 1'b1;
                shift_in  = lit;
                char_nxt  = lit;
                valid_nxt = 1'b1;
                if (lit == END_CHAR) begin
                    state_nxt  = DONE;
                    finish_nxt = 1'b1;
                end else begin
                    state_nxt = IDLE;
                end
            end
            DONE: begin
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        // busy is registered, so it is high exactly while the decoder is not IDLE.
        busy_nxt = (state_nxt != IDLE);
    end

    assign bus.busy     = busy_r;
    assign bus.valid    = valid_r;
    assign bus.char_out = char_r;
    assign bus.finish   = finish_r;

endmodule

// File: tb/tb_lz_token_decoder.sv
// tb/tb_lz_token_decoder.sv - scoreboard bench for lz_token_decoder with a history-based model
module tb_lz_token_decoder;

    logic clk;
    logic reset;

    lz_token_decoder_if bus ();

    lz_token_decoder dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    // Expected outputs: {finish, char}
    logic [8:0] exp_q [$];
    // Every character produced since the last reset, oldest first.
    logic [7:0] hist [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // A copy reads "off+1 characters back"; anything before the start of
    // history or beyond the 9-entry window reads as zero.
    function automatic void model_token(input int off, input int len, input logic [7:0] ch);
        logic [7:0] b;
        for (int k = 0; k < len; k++) begin
            b = 8'h00;
            if (off < 9 && off < hist.size()) begin
                b = hist[hist.size() - 1 - off];
            end
            hist.push_back(b);
            exp_q.push_back({1'b0, b});
        end
        hist.push_back(ch);
        exp_q.push_back({(ch == 8'h24), ch});
    endfunction

    always @(negedge clk) begin
        logic [8:0] e;
        if (!reset && bus.valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_output", {23'd0, bus.finish, bus.char_out}, 32'h1ff);
            end else begin
                e = exp_q.pop_front();
                check("char_out", {24'd0, bus.char_out}, {24'd0, e[7:0]});
                check("finish_with_char", {31'd0, bus.finish}, {31'd0, e[8]});
            end
        end
    end

    task automatic do_reset();
        @(posedge clk);
        #2;
        reset = 1'b1;
        exp_q.delete();
        hist.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic send_token(input int off, input int len, input logic [7:0] ch, input bit measure);
        int n;
        n = 0;
        while (bus.busy && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (bus.busy) begin
            check("accept_timeout", 32'd1, 32'd0);
            return;
        end
        bus.token_valid  = 1'b1;
        bus.token_offset = 4'(off);
        bus.token_len    = 4'(len);
        bus.token_char   = ch;
        model_token(off, len, ch);
        @(posedge clk);
        #1;
        bus.token_valid = 1'b0;
        if (measure) begin
            n = 0;
            while (bus.busy && n < 40) begin
                n++;
                @(posedge clk);
                #1;
            end
            check("busy_cycles", n, len + 1);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain", exp_q.size(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not end");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] ch;
        int off;
        int len;

        reset            = 1'b1;
        bus.token_valid  = 1'b0;
        bus.token_offset = '0;
        bus.token_len    = '0;
        bus.token_char   = '0;

        @(posedge clk);
        #1;
        check("reset_busy", bus.busy, 0);
        check("reset_valid", bus.valid, 0);
        check("reset_char", bus.char_out, 0);
        check("reset_finish", bus.finish, 0);
        reset = 1'b0;

        // Literal stream
        send_token(0, 0, "A", 1);
        send_token(0, 0, "B", 1);
        drain();

        // Overlapping copy
        do_reset();
        send_token(0, 0, "A", 1);
        send_token(0, 3, "C", 1);
        drain();

        // Window edge
        do_reset();
        for (int i = 1; i <= 9; i++) begin
            send_token(0, 0, 8'(i), 1);
        end
        send_token(8, 2, "x", 1);
        send_token(9, 1, "y", 1);
        drain();

        // Random tokens
        do_reset();
        for (int t = 0; t < 40; t++) begin
            off = $urandom_range(0, 15);
            len = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 15);
            ch  = 8'($urandom_range(0, 254));
            if (ch >= 8'h24) ch = ch + 8'd1;
            send_token(off, len, ch, 1);
        end
        drain();

        // Reset in the third output cycle of a copy
        do_reset();
        send_token(0, 5, "Z", 0);
        @(posedge clk);
        @(posedge clk);
        @(posedge clk);
        #2;
        reset = 1'b1;
        exp_q.delete();
        hist.delete();
        #1;
        check("async_rst_busy", bus.busy, 0);
        check("async_rst_valid", bus.valid, 0);
        check("async_rst_char", bus.char_out, 0);
        check("async_rst_finish", bus.finish, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        send_token(0, 1, "Q", 1);
        drain();

        // Terminator and DONE
        do_reset();
        send_token(0, 0, "A", 1);
        send_token(0, 0, "B", 1);
        send_token(1, 2, "$", 0);
        drain();
        @(posedge clk);
        #1;
        check("done_finish", bus.finish, 1);
        check("done_busy", bus.busy, 1);
        for (int i = 0; i < 5; i++) begin
            bus.token_valid  = 1'b1;
            bus.token_offset = '0;
            bus.token_len    = '0;
            bus.token_char   = "K";
            @(posedge clk);
            #1;
            check("done_valid_low", bus.valid, 0);
            check("done_busy_held", bus.busy, 1);
            check("done_finish_held", bus.finish, 1);
        end
        bus.token_valid = 1'b0;
        @(posedge clk);
        #1;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
